// File: rtl/uart_send.sv
// UART transmitter: start bit, 8 data bits sent LSB first, an optional parity bit, and a stop bit.
// Uses the same baud-select table as uart_rec. Every output is driven straight from a flop.
module uart_send #(
  parameter int CLK_IN     = 50_000_000,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_en,
  input  logic [7:0] data_byte,
  input  logic [1:0] bps_set,
  output logic       rs232_tx,
  output logic       tx_done,
  output logic       tx_state
);

  // state  | meaning
  // IDLE   | line high, waiting for send_en
  // START  | start bit (low)
  // DATA   | data bits 0..7, LSB first
  // PARITY | parity bit (only when PARITY_EN)
  // STOP   | stop bit (high); its last cycle is spent in IDLE with tx_done high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [12:0] CYC_9600   = 13'(CLK_IN / 9600);
  localparam logic [12:0] CYC_19200  = 13'(CLK_IN / 19200);
  localparam logic [12:0] CYC_38400  = 13'(CLK_IN / 38400);
  localparam logic [12:0] CYC_921600 = 13'(CLK_IN / 921600);

  state_t      state;
  logic [12:0] div_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  data_q;
  logic [1:0]  bps_q;
  logic [12:0] cyc_last;
  logic        bit_end;

  always_comb begin
    cyc_last = CYC_9600 - 13'd1;
    case (bps_q)
      2'b00:   cyc_last = CYC_9600 - 13'd1;
      2'b01:   cyc_last = CYC_19200 - 13'd1;
      2'b10:   cyc_last = CYC_38400 - 13'd1;
      default: cyc_last = CYC_921600 - 13'd1;
    endcase
  end

  assign bit_end = (div_cnt == cyc_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      bps_q    <= '0;
      rs232_tx <= 1'b1;
      tx_done  <= 1'b0;
      tx_state <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          rs232_tx <= 1'b1;
          div_cnt  <= '0;
          if (send_en) begin
            data_q   <= data_byte;
            bps_q    <= bps_set;
            state    <= S_START;
            rs232_tx <= 1'b0;
            tx_state <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            div_cnt  <= '0;
            bit_idx  <= '0;
            rs232_tx <= data_q[0];
            state    <= S_DATA;
          end else begin
            div_cnt <= div_cnt + 13'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN) begin
                state    <= S_PARITY;
                rs232_tx <= (^data_q) ^ PARITY_ODD;
              end else begin
                state    <= S_STOP;
                rs232_tx <= 1'b1;
              end
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              rs232_tx <= data_q[bit_idx + 3'd1];
            end
          end else begin
            div_cnt <= div_cnt + 13'd1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            div_cnt  <= '0;
            state    <= S_STOP;
            rs232_tx <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 13'd1;
          end
        end
        S_STOP: begin
          // leave one cycle early so a request during tx_done starts with no gap
          if (div_cnt == cyc_last - 13'd1) begin
            div_cnt  <= '0;
            state    <= S_IDLE;
            tx_done  <= 1'b1;
            tx_state <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 13'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send: one plain instance and two parity instances (even and odd).
// A per-cycle frame sampler samples each bit at mid-bit, checks bit timing, and acts as the loopback receiver.
`timescale 1ns/1ps
module tb_uart_send;
  logic       clk = 1'b0;
  logic       rst;
  logic       send_en, send_en_p;
  logic [7:0] data_byte;
  logic [1:0] bps_set;
  logic       tx0, done0, busy0;
  logic       tx1, done1, busy1;
  logic       tx2, done2, busy2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_send #(.CLK_IN(50_000_000), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .send_en(send_en), .data_byte(data_byte), .bps_set(bps_set),
    .rs232_tx(tx0), .tx_done(done0), .tx_state(busy0));
  uart_send #(.CLK_IN(50_000_000), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
    .clk(clk), .rst(rst), .send_en(send_en_p), .data_byte(data_byte), .bps_set(bps_set),
    .rs232_tx(tx1), .tx_done(done1), .tx_state(busy1));
  uart_send #(.CLK_IN(50_000_000), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
    .clk(clk), .rst(rst), .send_en(send_en_p), .data_byte(data_byte), .bps_set(bps_set),
    .rs232_tx(tx2), .tx_done(done2), .tx_state(busy2));

  function automatic logic line_of(input int s);
    return (s == 0) ? tx0 : (s == 1) ? tx1 : tx2;
  endfunction
  function automatic logic done_of(input int s);
    return (s == 0) ? done0 : (s == 1) ? done1 : done2;
  endfunction
  function automatic logic busy_of(input int s);
    return (s == 0) ? busy0 : (s == 1) ? busy1 : busy2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input int sel, input logic [7:0] d, input logic [1:0] b);
    data_byte = d;
    bps_set   = b;
    if (sel == 0) send_en = 1'b1; else send_en_p = 1'b1;
    @(negedge clk);
    send_en   = 1'b0;
    send_en_p = 1'b0;
  endtask

  // Samples one frame cycle by cycle starting at the first low cycle (index 0).
  task automatic run_frame(input int sel, input int bc, input int nb,
                           output logic [10:0] bits, output int done_at, output int n_done,
                           output int glitch, output int low_cnt, output int waited);
    logic prev;
    bits = '0; done_at = -1; n_done = 0; glitch = 0; low_cnt = 0; waited = 0;
    while (line_of(sel) !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (line_of(sel) !== 1'b0) begin
      check_eq("start_seen", {31'b0, line_of(sel)}, 32'd0);
      return;
    end
    prev = 1'b0;
    for (int i = 0; i < nb * bc; i++) begin
      if (line_of(sel) == 1'b0) low_cnt++;
      if (line_of(sel) !== prev && (i % bc) != 0) glitch++;
      prev = line_of(sel);
      if ((i % bc) == bc / 2) bits[i / bc] = line_of(sel);
      if (done_of(sel) === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = i;
      end
      @(negedge clk);
    end
  endtask

  logic [10:0] bits, bits2;
  int done_at, n_done, glitch, low_cnt, waited;
  int done_at2, n_done2, glitch2, low_cnt2, waited2;
  int cnt_a, cnt_b;
  logic [7:0]  lb_byte [3] = '{8'h00, 8'hFF, 8'h5A};
  logic [1:0]  lb_bps  [3] = '{2'b11, 2'b11, 2'b10};
  int          lb_bc   [3] = '{54, 54, 1302};

  initial begin
    rst = 1'b1; send_en = 1'b1; send_en_p = 1'b1; data_byte = 8'hA5; bps_set = 2'b11;

    // reset held with send_en high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_outputs", {29'b0, tx0, busy0, done0}, 32'h4);
    end
    rst = 1'b0; send_en = 1'b0; send_en_p = 1'b0;
    cnt_a = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) cnt_a++;
    end
    check_eq("post_rst_idle", cnt_a, 0);

    // single frame A5 at 921600
    send_req(0, 8'hA5, 2'b11);
    run_frame(0, 54, 10, bits, done_at, n_done, glitch, low_cnt, waited);
    check_eq("a5_bits", bits, {1'b1, 8'hA5, 1'b0});
    check_eq("a5_done_at", done_at, 539);
    check_eq("a5_done_cnt", n_done, 1);
    check_eq("a5_glitch", glitch, 0);
    check_eq("a5_end_idle", {30'b0, tx0, busy0}, 32'h2);

    // parity even then odd
    send_req(1, 8'hA5, 2'b11);
    run_frame(1, 54, 11, bits, done_at, n_done, glitch, low_cnt, waited);
    check_eq("par_even_bits", bits, {1'b1, 1'b0, 8'hA5, 1'b0});
    check_eq("par_even_done_at", done_at, 593);
    check_eq("par_even_glitch", glitch, 0);
    send_req(1, 8'hA5, 2'b11);
    run_frame(2, 54, 11, bits, done_at, n_done, glitch, low_cnt, waited);
    check_eq("par_odd_bits", bits, {1'b1, 1'b1, 8'hA5, 1'b0});
    check_eq("par_odd_done_at", done_at, 593);

    // 9600 baud, 0x00, bps/data changed mid-frame
    send_req(0, 8'h00, 2'b00);
    fork
      run_frame(0, 5208, 10, bits, done_at, n_done, glitch, low_cnt, waited);
      begin
        repeat (1000) @(negedge clk);
        bps_set = 2'b11; data_byte = 8'hFF;
      end
    join
    check_eq("b00_bits", bits, {1'b1, 8'h00, 1'b0});
    check_eq("b00_low_cycles", low_cnt, 46872);
    check_eq("b00_done_at", done_at, 52079);
    check_eq("b00_glitch", glitch, 0);

    // request while busy is ignored
    send_req(0, 8'h81, 2'b11);
    fork
      run_frame(0, 54, 10, bits, done_at, n_done, glitch, low_cnt, waited);
      begin
        repeat (100) @(negedge clk);
        data_byte = 8'h3C; send_en = 1'b1;
        @(negedge clk);
        send_en = 1'b0;
      end
    join
    check_eq("busy_bits", bits, {1'b1, 8'h81, 1'b0});
    cnt_a = 0;
    repeat (200) begin
      if (tx0 !== 1'b1 || busy0 !== 1'b0) cnt_a++;
      @(negedge clk);
    end
    check_eq("busy_ignored", cnt_a, 0);

    // back-to-back with send_en held high
    data_byte = 8'h55; bps_set = 2'b11; send_en = 1'b1;
    fork
      begin
        run_frame(0, 54, 10, bits, done_at, n_done, glitch, low_cnt, waited);
        run_frame(0, 54, 10, bits2, done_at2, n_done2, glitch2, low_cnt2, waited2);
      end
      begin
        repeat (10) @(negedge clk);
        data_byte = 8'hAA;
        repeat (590) @(negedge clk);
        send_en = 1'b0;
      end
    join
    check_eq("b2b_first_bits", bits, {1'b1, 8'h55, 1'b0});
    check_eq("b2b_first_done", n_done, 1);
    check_eq("b2b_second_bits", bits2, {1'b1, 8'hAA, 1'b0});
    check_eq("b2b_second_done", n_done2, 1);
    check_eq("b2b_gap", waited2, 0);
    check_eq("b2b_end_idle", {30'b0, tx0, busy0}, 32'h2);

    // reset during data bit 3 (frame index 240)
    send_req(0, 8'h00, 2'b11);
    repeat (240) @(negedge clk);
    check_eq("pre_rst_low", {31'b0, tx0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_outputs", {29'b0, tx0, busy0, done0}, 32'h4);
    rst = 1'b0;
    cnt_a = 0; cnt_b = 0;
    repeat (600) begin
      if (done0 === 1'b1) cnt_a++;
      if (tx0 !== 1'b1) cnt_b++;
      @(negedge clk);
    end
    check_eq("abort_no_done", cnt_a, 0);
    check_eq("abort_line_high", cnt_b, 0);
    send_req(0, 8'hC3, 2'b11);
    run_frame(0, 54, 10, bits, done_at, n_done, glitch, low_cnt, waited);
    check_eq("after_abort_bits", bits, {1'b1, 8'hC3, 1'b0});
    check_eq("after_abort_done_at", done_at, 539);

    // loopback through the mid-bit sampler
    for (int k = 0; k < 3; k++) begin
      send_req(0, lb_byte[k], lb_bps[k]);
      run_frame(0, lb_bc[k], 10, bits, done_at, n_done, glitch, low_cnt, waited);
      check_eq("loop_byte", {24'b0, bits[8:1]}, {24'b0, lb_byte[k]});
      check_eq("loop_frame", bits, {1'b1, lb_byte[k], 1'b0});
      check_eq("loop_done_at", done_at, 10 * lb_bc[k] - 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
